cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle instruction sequencer for the RV32I core. Walks each instruction through FETCH → DECODE → EXEC → (MEM) → WB, drives the datapath strobes and the memory request handshake, and enters a sticky TRAP state when the opcode decoder flags an illegal instruction. Sits between the instruction register / `control` decoder and the register file, ALU, PC and memory port.

## Interface
Parameters:
- `INSTRET_W`, 32, width of retired-instruction counter (only with `SEQ_INSTRET_EN`)

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `op_code`  in  7  opcode field `ir[6:0]`; valid from DECODE onward
- `op_illegal`  in  1  from `control`; sampled only in DECODE
- `branch_taken`  in  1  ALU compare result; sampled only in WB
- `mem_ready`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory request; held until `mem_ready`
- `mem_we`  out  1  write qualifier for `mem_req`
- `addr_sel`  out  1  0 = PC drives address, 1 = ALU result
- `ir_write`  out  1  load instruction register
- `alu_en`  out  1  ALU operand/result register enable
- `reg_write`  out  1  register-file write enable
- `pc_write`  out  1  PC update enable
- `pc_branch`  out  1  PC source: 0 = PC+4, 1 = branch target
- `trap`  out  1  sticky illegal-instruction flag
- `state`  out  3  current state, for debug
- `instret`  out  `INSTRET_W`  retired count (only with `SEQ_INSTRET_EN`)

## Operation
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 are unreachable and go to TRAP.
- Supported opcodes: OP 0110011, OP-IMM 0010011, LUI 0110111, LOAD 0000011, STORE 0100011, BRANCH 1100011. Any other opcode, or `op_illegal`=1, is illegal.
- FETCH: `mem_req`=1, `mem_we`=0, `addr_sel`=0. In the cycle `mem_ready`=1: `ir_write`=1 and go to DECODE. Otherwise stay in FETCH.
- DECODE: if illegal, go to TRAP. Otherwise latch the opcode class into an internal register, which is held through WB, and go to EXEC.
- EXEC: `alu_en`=1 for one cycle. LOAD or STORE goes to MEM; every other class goes to WB.
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we`=1 only for STORE. Stay until `mem_ready`=1, then go to WB.
- WB: `pc_write`=1. `pc_branch`=`branch_taken` for BRANCH, else 0. `reg_write`=1 for OP, OP-IMM, LUI and LOAD. Go to FETCH.
- TRAP: `trap`=1 and every other strobe is 0. The block stays in TRAP until `rst`.
- All strobes are decoded from the registered state plus the latched class. No output depends combinationally on `op_code` outside DECODE.

## Timing
- Reset: while `rst`=1 every output is 0, `state`=0 and `instret`=0. On the first cycle after `rst` deasserts, the block is in FETCH with `mem_req`=1.
- Reset mid-operation: any outstanding request is abandoned. `mem_req` is 0 in the reset cycle, and a `mem_ready` arriving during reset is ignored.
- Handshake: a request completes in the cycle where `mem_req`=1 and `mem_ready`=1. `mem_req` deasserts the next cycle. `mem_req` never drops before `mem_ready`, and `mem_we` and `addr_sel` stay stable for the whole request.
- Latency with zero-wait memory (`mem_ready` tied high):
  - OP, OP-IMM, LUI, BRANCH: 4 cycles.
  - LOAD, STORE: 5 cycles.
  - Each wait cycle adds 1.
- `mem_ready` outside FETCH and MEM is ignored.
- `ir_write`, `alu_en`, `reg_write` and `pc_write` are single-cycle pulses per instruction.

## Configuration
- `SEQ_INSTRET_EN` defined: `instret` exists. It increments by 1 on every WB cycle, wraps modulo 2^`INSTRET_W`, does not increment in TRAP, and clears on `rst`.
- `SEQ_INSTRET_EN` undefined: the `instret` port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then OP-IMM (0010011) with `mem_ready`=1 → `state` 0,1,2,4,0. `ir_write` pulses in cycle 1, `alu_en` in cycle 3, `reg_write` and `pc_write` in cycle 4.
- LOAD with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEM → `mem_req` held throughout, `addr_sel`=1 in MEM, `reg_write` in WB, total 10 cycles.
- STORE → `mem_we`=1 only in MEM and `reg_write`=0 in WB. BRANCH with `branch_taken`=1 → `pc_branch`=1 with `pc_write`; with `branch_taken`=0 → `pc_branch`=0.
- Opcode 0000000 (or `op_illegal`=1) in DECODE → TRAP in the next cycle with `trap`=1. It stays there for 20 cycles with `mem_req`=0, and `rst` returns it to FETCH.
- Assert `rst` in MEM with `mem_ready`=1 → all outputs 0 that cycle, next cycle FETCH with `mem_req`=1, and no WB or `reg_write` occurs.
- `SEQ_INSTRET_EN`, `INSTRET_W`=4, 17 OP instructions → `instret`=1 (wrap); a trapped instruction does not increment it.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with sticky illegal-op TRAP.
// Optional retired-instruction counter: define SEQ_INSTRET_EN.
module cpu_sequencer #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op_code,
  input  logic       op_illegal,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       alu_en,
  output logic       reg_write,
  output logic       pc_write,
  output logic       pc_branch,
  output logic       trap,
  output logic [2:0] state
`ifdef SEQ_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_OP     = 3'd0,
    C_IMM    = 3'd1,
    C_LUI    = 3'd2,
    C_LOAD   = 3'd3,
    C_STORE  = 3'd4,
    C_BRANCH = 3'd5
  } cls_e;

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;
  cls_e   dec_cls;
  logic   dec_ok;

  always_comb begin
    dec_cls = C_OP;
    dec_ok  = 1'b1;
    case (op_code)
      7'b0110011: dec_cls = C_OP;
      7'b0010011: dec_cls = C_IMM;
      7'b0110111: dec_cls = C_LUI;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // op_code only steers the next state in DECODE; strobes never see it
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op_illegal || !dec_ok) begin
          state_d = S_TRAP;
        end else begin
          cls_d   = dec_cls;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls_q == C_LOAD || cls_q == C_STORE)
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready) state_d = S_WB;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_OP;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Gated by rst so an abandoned request drops in the reset cycle itself
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    alu_en    = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_branch = 1'b0;
    trap      = 1'b0;
    state     = 3'd0;
    if (!rst) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        S_EXEC: alu_en = 1'b1;
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (cls_q == C_STORE);
        end
        S_WB: begin
          pc_write  = 1'b1;
          pc_branch = (cls_q == C_BRANCH) && branch_taken;
          reg_write = (cls_q == C_OP) || (cls_q == C_IMM) ||
                      (cls_q == C_LUI) || (cls_q == C_LOAD);
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SEQ_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst)
      instret_q <= '0;
    else if (state_q == S_WB)
      instret_q <= instret_q + INSTRET_W'(1);
  end

  assign instret = rst ? '0 : instret_q;
`else
  logic unused_instret_w;
  assign unused_instret_w = (INSTRET_W == 0);
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed table-driven bench for cpu_sequencer.
// Define SEQ_INSTRET_EN to also exercise the retired counter.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op_code;
  logic       op_illegal;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, addr_sel, ir_write, alu_en;
  logic       reg_write, pc_write, pc_branch, trap;
  logic [2:0] state;
`ifdef SEQ_INSTRET_EN
  logic [3:0] instret;
`endif

  always #5 clk = ~clk;

  cpu_sequencer #(.INSTRET_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_code      (op_code),
    .op_illegal   (op_illegal),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .ir_write     (ir_write),
    .alu_en       (alu_en),
    .reg_write    (reg_write),
    .pc_write     (pc_write),
    .pc_branch    (pc_branch),
    .trap         (trap),
    .state        (state)
`ifdef SEQ_INSTRET_EN
    ,
    .instret      (instret)
`endif
  );

  // {state, req, we, addr_sel, ir_wr, alu, reg_wr, pc_wr, pc_br, trap}
  logic [11:0] act;
  assign act = {state, mem_req, mem_we, addr_sel, ir_write, alu_en,
                reg_write, pc_write, pc_branch, trap};

  localparam logic [11:0] Z    = 12'h000;
  localparam logic [11:0] FW   = {3'd0, 9'b100000000};
  localparam logic [11:0] FG   = {3'd0, 9'b100100000};
  localparam logic [11:0] DC   = {3'd1, 9'b000000000};
  localparam logic [11:0] EX   = {3'd2, 9'b000010000};
  localparam logic [11:0] MLD  = {3'd3, 9'b101000000};
  localparam logic [11:0] MST  = {3'd3, 9'b111000000};
  localparam logic [11:0] WRW  = {3'd4, 9'b000001100};
  localparam logic [11:0] WPC  = {3'd4, 9'b000000100};
  localparam logic [11:0] WBR  = {3'd4, 9'b000000110};
  localparam logic [11:0] TRP  = {3'd5, 9'b000000001};

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b0000000;

  typedef struct {
    logic        r;
    logic [6:0]  op;
    logic        il;
    logic        bt;
    logic        rd;
    logic [11:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic [6:0] op,
                     input logic il, input logic bt, input logic rd,
                     input logic [11:0] exp, input string nm);
    vec_t v;
    v.r = r; v.op = op; v.il = il; v.bt = bt; v.rd = rd;
    v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endtask

  // Called just after a falling edge; checks, then advances one cycle
  task automatic cyc(input logic r, input logic [6:0] op,
                     input logic il, input logic bt, input logic rd,
                     input logic [11:0] exp, input string nm);
    rst = r; op_code = op; op_illegal = il;
    branch_taken = bt; mem_ready = rd;
    #1;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; op_code = '0; op_illegal = 1'b0;
    branch_taken = 1'b0; mem_ready = 1'b1;

    add(1, OP,  0, 0, 1, Z,   "reset0");
    add(1, OP,  0, 0, 1, Z,   "reset1");
    add(0, IMM, 0, 0, 1, FG,  "imm_fetch");
    add(0, IMM, 0, 0, 1, DC,  "imm_decode");
    add(0, IMM, 0, 0, 1, EX,  "imm_exec");
    add(0, IMM, 0, 0, 1, WRW, "imm_wb");
    add(0, LD,  0, 0, 0, FW,  "ld_fwait0");
    add(0, LD,  0, 0, 0, FW,  "ld_fwait1");
    add(0, LD,  0, 0, 1, FG,  "ld_fetch");
    add(0, LD,  0, 0, 1, DC,  "ld_decode");
    add(0, LD,  0, 0, 1, EX,  "ld_exec");
    add(0, LD,  0, 0, 0, MLD, "ld_mwait0");
    add(0, LD,  0, 0, 0, MLD, "ld_mwait1");
    add(0, LD,  0, 0, 0, MLD, "ld_mwait2");
    add(0, LD,  0, 0, 1, MLD, "ld_mem");
    add(0, LD,  0, 0, 1, WRW, "ld_wb");
    add(0, ST,  0, 0, 1, FG,  "st_fetch");
    add(0, ST,  0, 0, 1, DC,  "st_decode");
    add(0, ST,  0, 0, 1, EX,  "st_exec");
    add(0, ST,  0, 0, 1, MST, "st_mem");
    add(0, ST,  0, 0, 1, WPC, "st_wb");
    add(0, BR,  0, 0, 1, FG,  "bt_fetch");
    add(0, BR,  0, 0, 1, DC,  "bt_decode");
    add(0, BR,  0, 0, 1, EX,  "bt_exec");
    add(0, BR,  0, 1, 1, WBR, "bt_wb_taken");
    add(0, BR,  0, 1, 1, FG,  "bn_fetch");
    add(0, BR,  0, 1, 1, DC,  "bn_decode");
    add(0, BR,  0, 1, 1, EX,  "bn_exec");
    add(0, BR,  0, 0, 1, WPC, "bn_wb_not");
    add(0, OP,  0, 0, 1, FG,  "op_fetch");
    add(0, OP,  0, 0, 1, DC,  "op_decode");
    add(0, OP,  0, 1, 1, EX,  "op_exec");
    add(0, OP,  0, 1, 1, WRW, "op_wb_bt_ignored");
    add(0, LUI, 0, 0, 1, FG,  "lui_fetch");
    add(0, LUI, 0, 0, 1, DC,  "lui_decode");
    add(0, LUI, 0, 0, 1, EX,  "lui_exec");
    add(0, LUI, 0, 0, 1, WRW, "lui_wb");
    add(0, LD,  0, 0, 1, FG,  "rm_fetch");
    add(0, LD,  0, 0, 1, DC,  "rm_decode");
    add(0, LD,  0, 0, 1, EX,  "rm_exec");
    add(1, LD,  0, 0, 1, Z,   "rm_reset_in_mem");
    add(0, OP,  0, 0, 0, FW,  "rm_refetch0");
    add(0, OP,  0, 0, 0, FW,  "rm_refetch1");
    add(0, OP,  0, 0, 1, FG,  "rm_fetch2");
    add(0, OP,  0, 0, 1, DC,  "rm_decode2");
    add(0, OP,  0, 0, 1, EX,  "rm_exec2");
    add(0, OP,  0, 0, 1, WRW, "rm_wb2");
    add(0, OP,  0, 0, 1, FG,  "il_fetch");
    add(0, OP,  1, 0, 1, DC,  "il_decode");
    add(0, OP,  0, 0, 1, TRP, "il_trap");

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].r, tbl[i].op, tbl[i].il, tbl[i].bt, tbl[i].rd,
          tbl[i].exp, tbl[i].nm);

    for (int i = 0; i < 20; i++)
      cyc(0, OP, 0, 1, 1, TRP, "trap_hold");
    cyc(1, OP, 0, 0, 1, Z,   "trap_reset");
    cyc(0, BAD, 0, 0, 1, FG, "bad_fetch");
    cyc(0, BAD, 0, 0, 1, DC, "bad_decode");
    cyc(0, OP, 0, 0, 1, TRP, "bad_trap");
    cyc(0, OP, 0, 0, 0, TRP, "bad_trap_hold");

`ifdef SEQ_INSTRET_EN
    cyc(1, OP, 0, 0, 1, Z, "ir_reset");
    chk("instret_reset", int'(instret), 0);
    for (int i = 0; i < 17; i++) begin
      cyc(0, OP, 0, 0, 1, FG,  "ir_fetch");
      cyc(0, OP, 0, 0, 1, DC,  "ir_decode");
      cyc(0, OP, 0, 0, 1, EX,  "ir_exec");
      cyc(0, OP, 0, 0, 1, WRW, "ir_wb");
    end
    chk("instret_wrap", int'(instret), 1);
    cyc(0, BAD, 0, 0, 1, FG,  "ir_bad_fetch");
    cyc(0, BAD, 0, 0, 1, DC,  "ir_bad_decode");
    cyc(0, OP,  0, 0, 1, TRP, "ir_bad_trap");
    cyc(0, OP,  0, 0, 1, TRP, "ir_bad_trap2");
    chk("instret_trap", int'(instret), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
